sign_restore: RTL and testbench
===============================

# sign_restore

Re-signs results coming back from the unsigned approximate multiplier array. Each operand pair is split into magnitude plus sign bit before it enters the multiplier. This block queues each pair's sign bits on issue. When the corresponding unsigned product magnitude returns, it pops the sign bits and emits the two's-complement signed product through a registered valid/ready output stage. It sits between the unsigned multiplier output and the PE accumulator.

## Interface
- P_BW, 16, width of the unsigned product magnitude
- OUT_BW, P_BW+1, width of the signed result (must be ≥ P_BW+1)
- DEPTH, 4, sign FIFO depth; power of two, ≥ multiplier latency + 1
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- sgn_valid  input  1  sign pair offered (asserted when operands enter the multiplier)
- a_sign  input  1  sign of operand A
- b_sign  input  1  sign of operand B
- sgn_ready  output  1  sign FIFO can accept (level < DEPTH)
- mag_valid  input  1  unsigned product magnitude offered
- mag  input  P_BW  unsigned product magnitude
- mag_ready  output  1  magnitude accepted this cycle if mag_valid
- out_valid  output  1  signed result valid
- out_data  output  OUT_BW  signed two's-complement product
- out_ready  input  1  downstream accepts result
- level  output  $clog2(DEPTH+1)  current sign FIFO occupancy
- err_underflow  output  1  sticky: magnitude offered while sign FIFO empty

## Operation
- Push: sgn_valid && sgn_ready writes s = a_sign ^ b_sign at wr_ptr, wr_ptr++ (wraps mod DEPTH).
- sgn_ready = (level != DEPTH). Full FIFO refuses a push even if a pop occurs the same cycle (no bypass).
- mag_ready = (!out_valid || out_ready) && (level != 0).
- Pop/accept: mag_valid && mag_ready reads s at rd_ptr, rd_ptr++ (wraps), loads the output register.
- Arithmetic: ext = zero-extend mag to OUT_BW. out_data ← s ? (~ext + 1) : ext, truncated to OUT_BW.
- mag = 0 with s = 1 gives 0. No saturation is needed because OUT_BW > P_BW.
- level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Empty FIFO has no bypass: a same-cycle push does not satisfy a pending mag.
- Output register:
  - set out_valid on accept;
  - clear out_valid when out_valid && out_ready && no new accept;
  - accept while out_valid && out_ready replaces out_data back-to-back.
  - out_data holds while out_valid && !out_ready.
- err_underflow: set on any cycle with mag_valid && level == 0. Cleared only by rst. The magnitude is not consumed (mag_ready low).
- Signs pair with magnitudes strictly in order. The multiplier must return products in issue order.

## Timing
- Reset (async assert, sync-released by the system): wr_ptr = rd_ptr = 0, level = 0, out_valid = 0, out_data = 0, err_underflow = 0, sgn_ready = 1, mag_ready = 0.
- Latency: mag accepted in cycle N gives out_valid = 1 and out_data valid in cycle N+1.
- Throughput: one result per cycle while out_ready = 1 and the FIFO is non-empty.
- A push in cycle N makes the sign poppable from cycle N+1 (level visible at N+1).
- Reset mid-operation discards all queued signs and any pending output immediately; no result is emitted after rst.
- mag_ready and sgn_ready are combinational from registered state and out_ready only. There are no paths from mag_valid or sgn_valid.

## Test plan
- Basic signs, P_BW = 16:
  - push (a,b) = (1,0), then mag = 0x0006 → out_data = 17'h1FFFA (−6) at N+1;
  - push (1,1), mag = 0x0006 → 17'h00006.
- Extreme magnitude: push (0,1), mag = 0x4000 (−128·−128 magnitude 16384) → 17'h1C000. Push (1,0), mag = 0 → 0.
- Full FIFO:
  - push 4 signs with mag_valid = 0 → level = 4, sgn_ready = 0;
  - a 5th sgn_valid is not accepted;
  - then stream 4 magnitudes with out_ready = 1 → 4 results in order on consecutive cycles, level returns to 0.
- Back-pressure:
  - hold out_ready = 0 with one result pending → out_data stable, mag_ready = 0, queued sign retained;
  - release → next result the following cycle.
- Underflow: assert mag_valid with level = 0 → mag_ready = 0, err_underflow = 1, and it stays 1 after later normal traffic until rst.
- Async reset: assert rst mid-stream with level = 3 and out_valid = 1 → all outputs at reset values within the same cycle. After release, a fresh push/mag pair produces the correct result with no stale sign.

Source files
------------

// File: rtl/sign_restore.sv
// Re-signs unsigned multiplier products: queues the XOR of each operand sign pair on issue
// and applies it to the matching returning magnitude through a registered output stage.
module sign_restore #(
   parameter int P_BW   = 16,
   parameter int OUT_BW = P_BW + 1,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sgn_valid,
   input  logic                       a_sign,
   input  logic                       b_sign,
   output logic                       sgn_ready,
   input  logic                       mag_valid,
   input  logic [P_BW-1:0]            mag,
   output logic                       mag_ready,
   output logic                       out_valid,
   output logic [OUT_BW-1:0]          out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       err_underflow
);

   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   generate
      if (OUT_BW < P_BW + 1) begin : g_bad_out_bw
         $error("sign_restore: OUT_BW must be at least P_BW+1");
      end
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("sign_restore: DEPTH must be a power of two, at least 2");
      end
   endgenerate

   logic [DEPTH-1:0]  sign_mem_q;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_BW-1:0] out_data_q, out_data_d;
   logic              err_q, err_d;

   logic              push, pop;
   logic              pop_sign;
   logic [OUT_BW-1:0] ext, neg;

   // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge.
   // Readies depend only on registered state and out_ready, never on the matching valid;
   // valids are not required to stay asserted across cycles.
   assign sgn_ready = (level_q != LVL_W'(DEPTH));
   assign mag_ready = (!out_valid_q || out_ready) && (level_q != '0);

   assign push = sgn_valid && sgn_ready;
   assign pop  = mag_valid && mag_ready;

   assign pop_sign = sign_mem_q[rd_ptr_q];
   assign ext      = {{(OUT_BW-P_BW){1'b0}}, mag};
   assign neg      = ~ext + OUT_BW'(1);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = err_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end

      // A fresh accept always wins over draining, giving back-to-back results.
      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = pop_sign ? neg : ext;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (mag_valid && (level_q == '0)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   // Sign storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         sign_mem_q[wr_ptr_q] <= a_sign ^ b_sign;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign level         = level_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_sign_restore.sv
// Directed and randomized checks of sign_restore against a queue-based behavioural model.
module tb_sign_restore;

   localparam int P_BW   = 16;
   localparam int OUT_BW = P_BW + 1;
   localparam int DEPTH  = 4;
   localparam int LVL_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sgn_valid = 1'b0, a_sign = 1'b0, b_sign = 1'b0;
   logic              sgn_ready;
   logic              mag_valid = 1'b0;
   logic [P_BW-1:0]   mag = '0;
   logic              mag_ready;
   logic              out_valid;
   logic [OUT_BW-1:0] out_data;
   logic              out_ready = 1'b0;
   logic [LVL_W-1:0]  level;
   logic              err_underflow;

   sign_restore #(.P_BW(P_BW), .OUT_BW(OUT_BW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .sgn_valid(sgn_valid), .a_sign(a_sign), .b_sign(b_sign), .sgn_ready(sgn_ready),
      .mag_valid(mag_valid), .mag(mag), .mag_ready(mag_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .level(level), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: queue of pending product signs plus the visible output.
   bit                sq[$];
   logic              m_ov = 1'b0;
   logic [OUT_BW-1:0] m_od = '0;
   logic              m_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [OUT_BW-1:0] signed_product(input bit s, input logic [P_BW-1:0] m);
      longint v;
      logic [63:0] bits;
      v    = s ? -longint'(m) : longint'(m);
      bits = v;
      return bits[OUT_BW-1:0];
   endfunction

   task automatic model_reset();
      sq.delete();
      m_ov  = 1'b0;
      m_od  = '0;
      m_err = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_data"}, 32'(out_data), 0);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_err"}, 32'(err_underflow), 0);
      chk({tag, "_sgn_ready"}, 32'(sgn_ready), 1);
      chk({tag, "_mag_ready"}, 32'(mag_ready), 0);
   endtask

   // One clock: drive inputs, check readies, advance, update model, check registered outputs.
   task automatic cycle(input logic sv, input logic a, input logic b,
                        input logic mv, input logic [P_BW-1:0] m, input logic ordy);
      bit e_sr, e_mr, s;
      sgn_valid = sv; a_sign = a; b_sign = b;
      mag_valid = mv; mag = m; out_ready = ordy;
      #1;
      e_sr = (sq.size() != DEPTH);
      e_mr = (!m_ov || ordy) && (sq.size() != 0);
      chk("sgn_ready", 32'(sgn_ready), 32'(e_sr));
      chk("mag_ready", 32'(mag_ready), 32'(e_mr));
      @(posedge clk);
      if (mv && sq.size() == 0) m_err = 1'b1;
      if (mv && e_mr) begin
         s    = sq.pop_front();
         m_ov = 1'b1;
         m_od = signed_product(s, m);
      end else if (m_ov && ordy) begin
         m_ov = 1'b0;
      end
      if (sv && e_sr) sq.push_back(a ^ b);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) chk("out_data", 32'(out_data), 32'(m_od));
      chk("level", 32'(level), sq.size());
      chk("err_underflow", 32'(err_underflow), 32'(m_err));
   endtask

   task automatic idle_inputs();
      sgn_valid = 0; a_sign = 0; b_sign = 0; mag_valid = 0; mag = '0; out_ready = 0;
   endtask

   initial begin
      logic [OUT_BW-1:0] held;
      // Power-on reset
      idle_inputs();
      #1;
      model_reset();
      check_reset_state("por");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_state("por_rel");

      // Basic signs
      cycle(1, 1, 0, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'h0006, 1);
      chk("basic_neg6", 32'(out_data), 32'h1FFFA);
      cycle(1, 1, 1, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'h0006, 1);
      chk("basic_pos6", 32'(out_data), 32'h00006);

      // Extreme magnitudes
      cycle(1, 0, 1, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'h4000, 1);
      chk("ext_neg4000", 32'(out_data), 32'h1C000);
      cycle(1, 1, 0, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'h0000, 1);
      chk("ext_negzero", 32'(out_data), 32'h00000);
      cycle(1, 0, 1, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'hFFFF, 1);
      chk("ext_negffff", 32'(out_data), 32'h10001);
      cycle(0, 0, 0, 0, 16'h0000, 1);

      // Full FIFO, refused fifth push, then streaming drain
      cycle(1, 1, 0, 0, 16'h0000, 1);
      cycle(1, 0, 0, 0, 16'h0000, 1);
      cycle(1, 1, 1, 0, 16'h0000, 1);
      cycle(1, 0, 1, 0, 16'h0000, 1);
      chk("full_level", 32'(level), 4);
      cycle(1, 1, 0, 0, 16'h0000, 1);
      chk("full_refuse", 32'(level), 4);
      cycle(0, 0, 0, 1, 16'h0011, 1);
      chk("drain0", 32'(out_data), 32'h1FFEF);
      cycle(0, 0, 0, 1, 16'h0022, 1);
      chk("drain1", 32'(out_data), 32'h00022);
      cycle(0, 0, 0, 1, 16'h0033, 1);
      chk("drain2", 32'(out_data), 32'h00033);
      cycle(0, 0, 0, 1, 16'h0044, 1);
      chk("drain3", 32'(out_data), 32'h1FFBC);
      chk("drain_level", 32'(level), 0);
      cycle(0, 0, 0, 0, 16'h0000, 1);

      // Back-pressure with one result pending and one sign queued
      cycle(1, 1, 0, 0, 16'h0000, 1);
      cycle(1, 1, 1, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'h0100, 0);
      held = out_data;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 16'h0200, 0);
         chk("bp_hold", 32'(out_data), 32'(held));
         chk("bp_level", 32'(level), 1);
      end
      cycle(0, 0, 0, 1, 16'h0200, 1);
      chk("bp_release", 32'(out_data), 32'h00200);
      cycle(0, 0, 0, 0, 16'h0000, 1);

      // Underflow: sticky until reset
      cycle(0, 0, 0, 1, 16'h0005, 1);
      chk("uf_set", 32'(err_underflow), 1);
      cycle(1, 0, 0, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'h0007, 1);
      cycle(0, 0, 0, 0, 16'h0000, 1);
      chk("uf_sticky", 32'(err_underflow), 1);

      // Async reset mid-stream with level 3 and a pending result
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 16'h0000, 0);
      cycle(0, 0, 0, 1, 16'h0009, 0);
      chk("pre_rst_level", 32'(level), 3);
      chk("pre_rst_valid", 32'(out_valid), 1);
      idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_state("async");
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(1, 0, 0, 0, 16'h0000, 1);
      cycle(0, 0, 0, 1, 16'h0123, 1);
      chk("post_rst", 32'(out_data), 32'h00123);
      cycle(0, 0, 0, 0, 16'h0000, 1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
               P_BW'($urandom_range(0, 16'hFFFF)), logic'($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
